// File: rtl/exe_stage.sv
// Execute stage of a five-stage in-order pipeline.
//
// Latches one instruction from ID, computes its ALU result (or runs a 32-cycle
// shift-add multiply when mul_en is set), and offers the result to MEM under a
// valid/allow handshake. Memory requests are issued in the cycle the
// instruction is handed to MEM, so MEM sees the read data one cycle later.
//
// Ports:
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   id_to_exe_valid    upstream holds a valid instruction
//   id_to_exe_data     {mul_en, alu_op[3:0], mem_we, res_from_mem, gr_we, dest[4:0],
//                       src1, src2, st_data, pc, inst}
//   exe_allow          stage can accept an instruction this cycle
//   exe_to_mem_valid   stage offers a result to MEM
//   mem_allow          MEM can accept this cycle
//   exe_to_mem_data    {gr_we, res_from_mem, dest[4:0], pc, inst, alu_result}
//   data_sram_*        data SRAM request (word accesses only)
//   exe_wr             {load pending, register write pending, dest} for hazard logic
module exe_stage (
  input  logic          clk,
  input  logic          resetn,
  input  logic          id_to_exe_valid,
  input  logic [172:0]  id_to_exe_data,
  output logic          exe_allow,
  output logic          exe_to_mem_valid,
  input  logic          mem_allow,
  output logic [102:0]  exe_to_mem_data,
  output logic          data_sram_en,
  output logic [3:0]    data_sram_we,
  output logic [31:0]   data_sram_addr,
  output logic [31:0]   data_sram_wdata,
  output logic [6:0]    exe_wr
);

  typedef enum logic [1:0] {MulIdle, MulBusy, MulDone} mul_state_e;

  logic          exe_valid_q;
  logic [172:0]  payload_q;
  logic          exe_ready;
  logic          load;

  mul_state_e    mul_state_q;
  logic [5:0]    mul_cnt_q;
  logic [31:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [31:0]   product_q;

  // Latched payload fields
  logic          mul_en;
  logic [3:0]    alu_op;
  logic          mem_we;
  logic          res_from_mem;
  logic          gr_we;
  logic [4:0]    dest;
  logic [31:0]   src1;
  logic [31:0]   src2;
  logic [31:0]   st_data;
  logic [31:0]   pc;
  logic [31:0]   inst;

  logic [31:0]   alu_out;
  logic [31:0]   alu_result;

  assign {mul_en, alu_op, mem_we, res_from_mem, gr_we, dest,
          src1, src2, st_data, pc, inst} = payload_q;

  assign load = id_to_exe_valid & exe_allow;

  // Handshake
  assign exe_ready        = ~mul_en | (mul_state_q == MulDone);
  assign exe_to_mem_valid = exe_valid_q & exe_ready;
  assign exe_allow        = ~exe_valid_q | (exe_to_mem_valid & mem_allow);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      if (exe_allow) exe_valid_q <= id_to_exe_valid;
      if (load)      payload_q   <= id_to_exe_data;
    end
  end

  // Shift-add multiplier. A fresh load always wins, so an instruction arriving
  // on the hand-out edge of a finished multiply restarts the FSM directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_state_q <= MulIdle;
      mul_cnt_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      product_q   <= '0;
    end else if (load) begin
      if (id_to_exe_data[172]) begin
        mul_state_q <= MulBusy;
        mul_cnt_q   <= '0;
        product_q   <= '0;
        mcand_q     <= id_to_exe_data[159:128];
        mplier_q    <= id_to_exe_data[127:96];
      end else begin
        mul_state_q <= MulIdle;
      end
    end else begin
      unique case (mul_state_q)
        MulBusy: begin
          if (mplier_q[0]) product_q <= product_q + mcand_q;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          mul_cnt_q <= mul_cnt_q + 6'd1;
          if (mul_cnt_q == 6'd31) mul_state_q <= MulDone;
        end
        MulDone: begin
          if (exe_to_mem_valid && mem_allow) mul_state_q <= MulIdle;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      4'd0:    alu_out = src1 + src2;
      4'd1:    alu_out = src1 - src2;
      4'd2:    alu_out = {31'd0, $signed(src1) < $signed(src2)};
      4'd3:    alu_out = {31'd0, src1 < src2};
      4'd4:    alu_out = src1 & src2;
      4'd5:    alu_out = src1 | src2;
      4'd6:    alu_out = src1 ^ src2;
      4'd7:    alu_out = ~(src1 | src2);
      4'd8:    alu_out = src1 << src2[4:0];
      4'd9:    alu_out = src1 >> src2[4:0];
      4'd10:   alu_out = $unsigned($signed(src1) >>> src2[4:0]);
      4'd11:   alu_out = src2;
      default: alu_out = '0;
    endcase
  end

  assign alu_result = mul_en ? product_q : alu_out;

  assign exe_to_mem_data = {gr_we, res_from_mem, dest, pc, inst, alu_result};

  // Request only on the hand-over edge so it is issued exactly once.
  assign data_sram_en    = exe_to_mem_valid & mem_allow & (mem_we | res_from_mem);
  assign data_sram_we    = {4{data_sram_en & mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_data;

  assign exe_wr = {exe_valid_q & res_from_mem, exe_valid_q & gr_we, dest};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic          clk;
  logic          resetn;
  logic          id_to_exe_valid;
  logic [172:0]  id_to_exe_data;
  logic          exe_allow;
  logic          exe_to_mem_valid;
  logic          mem_allow;
  logic [102:0]  exe_to_mem_data;
  logic          data_sram_en;
  logic [3:0]    data_sram_we;
  logic [31:0]   data_sram_addr;
  logic [31:0]   data_sram_wdata;
  logic [6:0]    exe_wr;

  int errors = 0;
  int checks = 0;
  bit allow_seen;
  int ncyc;

  exe_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .id_to_exe_valid  (id_to_exe_valid),
    .id_to_exe_data   (id_to_exe_data),
    .exe_allow        (exe_allow),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_allow        (mem_allow),
    .exe_to_mem_data  (exe_to_mem_data),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .exe_wr           (exe_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [172:0] mk(input logic mul, input logic [3:0] op, input logic we,
                                      input logic rfm, input logic gw, input logic [4:0] dst,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] st, input logic [31:0] pc,
                                      input logic [31:0] inst);
    return {mul, op, we, rfm, gw, dst, s1, s2, st, pc, inst};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge.
  task automatic issue(input logic [172:0] d);
    id_to_exe_valid = 1'b1;
    id_to_exe_data  = d;
    step();
    id_to_exe_valid = 1'b0;
    #1;
  endtask

  // Cycle 1 is the cycle after the latching edge; bounded at 40.
  task automatic wait_valid(output int n);
    n = 1;
    allow_seen = 1'b0;
    while (!exe_to_mem_valid && n < 40) begin
      if (exe_allow) allow_seen = 1'b1;
      step();
      n++;
    end
  endtask

  logic [3:0]  t_op  [11];
  logic [31:0] t_s1  [11];
  logic [31:0] t_s2  [11];
  logic [31:0] t_exp [11];

  initial begin
    t_op[0]  = 4'd1;  t_s1[0]  = 32'd5;        t_s2[0]  = 32'd7;        t_exp[0]  = 32'hFFFFFFFE;
    t_op[1]  = 4'd3;  t_s1[1]  = 32'd1;        t_s2[1]  = 32'hFFFFFFFF; t_exp[1]  = 32'd1;
    t_op[2]  = 4'd2;  t_s1[2]  = 32'd1;        t_s2[2]  = 32'hFFFFFFFF; t_exp[2]  = 32'd0;
    t_op[3]  = 4'd4;  t_s1[3]  = 32'hFF00FF00; t_s2[3]  = 32'h0F0F0F0F; t_exp[3]  = 32'h0F000F00;
    t_op[4]  = 4'd5;  t_s1[4]  = 32'hFF00FF00; t_s2[4]  = 32'h0F0F0F0F; t_exp[4]  = 32'hFF0FFF0F;
    t_op[5]  = 4'd6;  t_s1[5]  = 32'hFF00FF00; t_s2[5]  = 32'h0F0F0F0F; t_exp[5]  = 32'hF00FF00F;
    t_op[6]  = 4'd7;  t_s1[6]  = 32'hFF00FF00; t_s2[6]  = 32'h0F0F0F0F; t_exp[6]  = 32'h00F000F0;
    t_op[7]  = 4'd8;  t_s1[7]  = 32'd1;        t_s2[7]  = 32'h23;       t_exp[7]  = 32'd8;
    t_op[8]  = 4'd9;  t_s1[8]  = 32'h80000000; t_s2[8]  = 32'd4;        t_exp[8]  = 32'h08000000;
    t_op[9]  = 4'd11; t_s1[9]  = 32'h11111111; t_s2[9]  = 32'h12345000; t_exp[9]  = 32'h12345000;
    t_op[10] = 4'd13; t_s1[10] = 32'h11111111; t_s2[10] = 32'h22222222; t_exp[10] = 32'd0;

    clk = 1'b0;
    resetn = 1'b0;
    id_to_exe_valid = 1'b0;
    id_to_exe_data = '0;
    mem_allow = 1'b1;

    // Reset state
    #12;
    check("rst_valid", exe_to_mem_valid, 1'b0);
    check("rst_allow", exe_allow, 1'b1);
    check("rst_en", data_sram_en, 1'b0);
    check("rst_we", data_sram_we, 4'h0);
    check("rst_wr", exe_wr, 7'h00);
    check("rst_data", exe_to_mem_data, 103'd0);
    resetn = 1'b1;
    step();

    // ADD wraps to zero, result visible the cycle after intake
    issue(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 32'd1, 32'd0,
             32'h1C000000, 32'h00001234));
    check("add_valid", exe_to_mem_valid, 1'b1);
    check("add_res", data_sram_addr, 32'h00000000);
    check("add_wr", exe_wr, 7'h23);
    check("add_en", data_sram_en, 1'b0);
    check("add_data", exe_to_mem_data,
          {1'b1, 1'b0, 5'd3, 32'h1C000000, 32'h00001234, 32'h00000000});

    // SRA then SLT, each intake overlapping the previous hand-out
    issue(mk(1'b0, 4'd10, 1'b0, 1'b0, 1'b1, 5'd4, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'd0));
    check("sra_res", data_sram_addr, 32'hF8000000);
    check("sra_valid", exe_to_mem_valid, 1'b1);
    issue(mk(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0));
    check("slt_res", data_sram_addr, 32'd1);

    // Remaining ALU ops
    for (int i = 0; i < 11; i++) begin
      issue(mk(1'b0, t_op[i], 1'b0, 1'b0, 1'b0, 5'd0, t_s1[i], t_s2[i], 32'd0, 32'd0, 32'd0));
      check($sformatf("alu_op%0d", t_op[i]), data_sram_addr, t_exp[i]);
    end

    // MUL latency and result
    issue(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00010001, 32'h00010001, 32'd0,
             32'd0, 32'd0));
    wait_valid(ncyc);
    check("mul_latency", ncyc, 33);
    check("mul_allow_low", allow_seen, 1'b0);
    check("mul_res", data_sram_addr, 32'h00020001);
    check("mul_wr", exe_wr, 7'h25);
    step();
    check("mul_gone", exe_to_mem_valid, 1'b0);

    // Store held under back-pressure, then one request
    mem_allow = 1'b0;
    issue(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h100, 32'd4, 32'hDEADBEEF, 32'd0, 32'd0));
    for (int i = 0; i < 3; i++) begin
      check("st_stall_en", data_sram_en, 1'b0);
      check("st_stall_we", data_sram_we, 4'h0);
      check("st_stall_valid", exe_to_mem_valid, 1'b1);
      check("st_stall_allow", exe_allow, 1'b0);
      step();
    end
    mem_allow = 1'b1;
    #1;
    check("st_en", data_sram_en, 1'b1);
    check("st_we", data_sram_we, 4'hF);
    check("st_addr", data_sram_addr, 32'h104);
    check("st_wdata", data_sram_wdata, 32'hDEADBEEF);
    step();
    check("st_done_en", data_sram_en, 1'b0);
    check("st_done_valid", exe_to_mem_valid, 1'b0);

    // Load: request without write enables, load-pending flag set
    issue(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h200, 32'd8, 32'd0, 32'd0, 32'd0));
    check("ld_en", data_sram_en, 1'b1);
    check("ld_we", data_sram_we, 4'h0);
    check("ld_wr", exe_wr, 7'h66);
    check("ld_addr", data_sram_addr, 32'h208);

    // Back-to-back ADD, ADD, MUL
    id_to_exe_valid = 1'b1;
    id_to_exe_data = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
    step();
    check("b2b_a1_res", data_sram_addr, 32'd3);
    check("b2b_a1_wr", exe_wr, 7'h27);
    check("b2b_a1_valid", exe_to_mem_valid, 1'b1);
    id_to_exe_data = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd8, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0);
    step();
    check("b2b_a2_res", data_sram_addr, 32'd11);
    check("b2b_a2_wr", exe_wr, 7'h08);
    check("b2b_a2_valid", exe_to_mem_valid, 1'b1);
    id_to_exe_data = mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'd3, 32'd7, 32'd0, 32'd0, 32'd0);
    step();
    id_to_exe_valid = 1'b0;
    #1;
    check("b2b_m_busy", exe_to_mem_valid, 1'b0);
    check("b2b_m_wr", exe_wr, 7'h29);
    wait_valid(ncyc);
    check("b2b_m_latency", ncyc, 33);
    check("b2b_m_res", data_sram_addr, 32'd21);
    step();

    // Reset in the middle of a multiply
    issue(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h12345678, 32'h9ABCDEF0, 32'd0,
             32'd0, 32'd0));
    for (int i = 0; i < 10; i++) step();
    resetn = 1'b0;
    #1;
    check("mrst_valid", exe_to_mem_valid, 1'b0);
    check("mrst_allow", exe_allow, 1'b1);
    check("mrst_wr", exe_wr, 7'h00);
    check("mrst_data", exe_to_mem_data, 103'd0);
    check("mrst_en", data_sram_en, 1'b0);
    #2;
    resetn = 1'b1;
    step();
    issue(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0));
    wait_valid(ncyc);
    check("mrst_latency", ncyc, 33);
    check("mrst_res", data_sram_addr, 32'h0000000F);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
